// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM encoding, frame
// start byte, error codes and small helpers used across the loader files.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT0,
        S_CNT1,
        S_DATA,
        S_WRITE,
        S_CHK
    } state_t;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_COUNT = 2'b01;
    localparam logic [1:0] ERR_SUM   = 2'b10;

    // Byte-index width inside a word; a one-byte word still needs a 1-bit index.
    function automatic int idx_width(input int step);
        return (step > 1) ? $clog2(step) : 1;
    endfunction

    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port of the loader, bundled so
// the source (master) and the loader (slave) see opposite directions.
interface program_loader_if #(
    parameter int INSTR_ADDR_WIDTH = 20,
    parameter int STEP             = 4
);

    logic [7:0]                  rx_data;
    logic                        rx_valid;
    logic                        rx_ready;
    logic                        pgm;
    logic [INSTR_ADDR_WIDTH-1:0] addr;
    logic [STEP*8-1:0]           data;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  pgm,
        input  addr,
        input  data
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output pgm,
        output addr,
        output data
    );

endinterface

// File: rtl/word_assembler.sv
// Collects STEP little-endian bytes into one memory word; byte k lands in
// bits [8k+7:8k] and last_byte flags the final byte slot of the word.
module word_assembler
    import loader_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [7:0]        byte_in,
    output logic [STEP*8-1:0] word,
    output logic              last_byte
);

    localparam int IDX_W = idx_width(STEP);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEP - 1);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [STEP*8-1:0] word_q, word_d;

    assign last_byte = (idx_q == LAST_IDX);
    assign word      = word_q;

    // clear wins over load so a new frame or a finished word always restarts at byte 0
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear) begin
            idx_d  = '0;
            word_d = '0;
        end else if (load) begin
            word_d[int'(idx_q)*8 +: 8] = byte_in;
            idx_d = last_byte ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Framed boot loader: parses MAGIC, 16-bit word count, data words and a
// mod-256 checksum, writing each assembled word to consecutive addresses.
module program_loader
    import loader_pkg::*;
#(
    parameter int         INSTR_ADDR_WIDTH = 20,
    parameter int         STEP             = 4,
    parameter logic [7:0] MAGIC            = MAGIC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    program_loader_if.slave bus,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [1:0]      err_code
);

    // Largest legal count is the full memory; wide memories accept any 16-bit count.
    localparam int unsigned MAX_WORDS_I = (INSTR_ADDR_WIDTH >= 16) ? 65536 : (1 << INSTR_ADDR_WIDTH);
    localparam logic [16:0] MAX_WORDS   = 17'(MAX_WORDS_I);

    state_t                      state_q, state_d;
    logic [INSTR_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [16:0]                 words_q, words_d;
    logic [7:0]                  sum_q, sum_d;
    logic [7:0]                  cnt_lo_q, cnt_lo_d;
    logic                        rx_ready_q, rx_ready_d;
    logic                        pgm_q, pgm_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        error_q, error_d;
    logic [1:0]                  err_code_q, err_code_d;

    logic                        accept;
    logic                        asm_clear;
    logic                        asm_load;
    logic                        last_byte;
    logic [15:0]                 count;
    logic [STEP*8-1:0]           word;

    assign accept = bus.rx_valid && rx_ready_q;
    assign count  = {bus.rx_data, cnt_lo_q};

    word_assembler #(
        .STEP (STEP)
    ) u_word_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .load      (asm_load),
        .byte_in   (bus.rx_data),
        .word      (word),
        .last_byte (last_byte)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        words_d    = words_q;
        sum_d      = sum_q;
        cnt_lo_d   = cnt_lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        err_code_d = err_code_q;
        asm_clear  = 1'b0;
        asm_load   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept && bus.rx_data == MAGIC) begin
                    state_d    = S_CNT0;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    sum_d      = '0;
                    addr_d     = '0;
                    busy_d     = 1'b1;
                    asm_clear  = 1'b1;
                end
            end
            S_CNT0: begin
                if (accept) begin
                    cnt_lo_d = bus.rx_data;
                    sum_d    = sum8(sum_q, bus.rx_data);
                    state_d  = S_CNT1;
                end
            end
            S_CNT1: begin
                if (accept) begin
                    sum_d = sum8(sum_q, bus.rx_data);
                    if ({1'b0, count} > MAX_WORDS) begin
                        error_d    = 1'b1;
                        err_code_d = ERR_COUNT;
                        busy_d     = 1'b0;
                        state_d    = S_IDLE;
                    end else if (count == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        words_d = {1'b0, count};
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    asm_load = 1'b1;
                    sum_d    = sum8(sum_q, bus.rx_data);
                    if (last_byte) begin
                        state_d = S_WRITE;
                    end
                end
            end
            // Single stall cycle: the write strobe is up and no byte is taken
            S_WRITE: begin
                addr_d    = addr_q + 1'b1;
                words_d   = words_q - 17'd1;
                asm_clear = 1'b1;
                state_d   = (words_q == 17'd1) ? S_CHK : S_DATA;
            end
            S_CHK: begin
                if (accept) begin
                    if (bus.rx_data == sum_q) begin
                        done_d = 1'b1;
                    end else begin
                        error_d    = 1'b1;
                        err_code_d = ERR_SUM;
                    end
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        rx_ready_d = (state_d != S_WRITE);
        pgm_d      = (state_d == S_WRITE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            words_q    <= '0;
            sum_q      <= '0;
            cnt_lo_q   <= '0;
            rx_ready_q <= 1'b0;
            pgm_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            words_q    <= words_d;
            sum_q      <= sum_d;
            cnt_lo_q   <= cnt_lo_d;
            rx_ready_q <= rx_ready_d;
            pgm_q      <= pgm_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.pgm      = pgm_q;
    assign bus.addr     = addr_q;
    assign bus.data     = word;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a table of whole frames with expected
// writes and status, plus hand sequences for stalls, full memory and reset.
module tb_program_loader;

    localparam int AW = 5;
    localparam int ST = 4;

    typedef struct {
        string       name;
        int          nbytes;
        logic [7:0]  bytes [0:15];
        bit          gaps;
        int          exp_writes;
        logic [AW-1:0] exp_addr [0:1];
        logic [31:0] exp_data [0:1];
        int          exp_done;
        logic        exp_error;
        logic [1:0]  exp_err_code;
    } frame_vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;

    int vectors = 0;
    int miscompares = 0;

    logic [AW-1:0] wr_addr [$];
    logic [31:0]   wr_data [$];
    int            done_cnt = 0;
    int            viol = 0;
    logic          prev_reset = 1'b1;

    frame_vec_t vecs [0:4];

    always #5 clk = ~clk;

    program_loader_if #(.INSTR_ADDR_WIDTH(AW), .STEP(ST)) bus ();

    program_loader #(
        .INSTR_ADDR_WIDTH (AW),
        .STEP             (ST),
        .MAGIC            (8'hA5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code)
    );

    // Records every write and flags cycle-level rule breaks outside reset
    always @(negedge clk) begin
        if (bus.pgm) begin
            wr_addr.push_back(bus.addr);
            wr_data.push_back(bus.data);
        end
        if (done) done_cnt++;
        if (!reset && !prev_reset) begin
            if (bus.rx_ready == bus.pgm) viol++;
            if (done && (error || busy)) viol++;
            if (bus.pgm && !busy) viol++;
        end
        prev_reset = reset;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, output int cycles);
        logic seen;
        cycles = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        do begin
            seen = bus.rx_ready;
            @(negedge clk);
            cycles++;
        end while (!seen && cycles < 20);
        bus.rx_valid = 1'b0;
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: byte 0x%0h not taken within %0d cycles", b, cycles);
        end
    endtask

    task automatic clearMonitor();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
        viol = 0;
    endtask

    function automatic frame_vec_t mkVec(input string name, input logic [7:0] bq [$], input bit gaps,
                                         input int writes, input logic [31:0] d0, input logic [31:0] d1,
                                         input int dn, input logic err, input logic [1:0] code);
        frame_vec_t v;
        v.name = name;
        v.nbytes = bq.size();
        for (int i = 0; i < 16; i++) v.bytes[i] = (i < bq.size()) ? bq[i] : 8'h00;
        v.gaps = gaps;
        v.exp_writes = writes;
        v.exp_addr[0] = 5'd0;
        v.exp_addr[1] = 5'd1;
        v.exp_data[0] = d0;
        v.exp_data[1] = d1;
        v.exp_done = dn;
        v.exp_error = err;
        v.exp_err_code = code;
        return v;
    endfunction

    task automatic applyStimulus(input frame_vec_t v);
        int c;
        clearMonitor();
        for (int i = 0; i < v.nbytes; i++) begin
            if (v.gaps) repeat (i % 3) @(negedge clk);
            sendByte(v.bytes[i], c);
        end
        repeat (3) @(negedge clk);
        checkOutput({v.name, "/writes"}, 64'(wr_addr.size()), 64'(v.exp_writes));
        for (int k = 0; k < wr_addr.size() && k < 2; k++) begin
            checkOutput({v.name, "/addr"}, 64'(wr_addr[k]), 64'(v.exp_addr[k]));
            checkOutput({v.name, "/data"}, 64'(wr_data[k]), 64'(v.exp_data[k]));
        end
        checkOutput({v.name, "/done"}, 64'(done_cnt), 64'(v.exp_done));
        checkOutput({v.name, "/error"}, 64'(error), 64'(v.exp_error));
        checkOutput({v.name, "/err_code"}, 64'(err_code), 64'(v.exp_err_code));
        checkOutput({v.name, "/busy"}, 64'(busy), 64'd0);
        checkOutput({v.name, "/rx_ready"}, 64'(bus.rx_ready), 64'd1);
        checkOutput({v.name, "/cycle_rules"}, 64'(viol), 64'd0);
    endtask

    initial begin
        logic [7:0] bq [$];
        int c;
        logic [7:0] sum;

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        bq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB8};
        vecs[0] = mkVec("basic", bq, 1'b0, 2, 32'h00000013, 32'h00100093, 1, 1'b0, 2'b00);
        vecs[4] = mkVec("gaps", bq, 1'b1, 2, 32'h00000013, 32'h00100093, 1, 1'b0, 2'b00);
        bq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB9};
        vecs[1] = mkVec("badsum", bq, 1'b0, 2, 32'h00000013, 32'h00100093, 0, 1'b1, 2'b10);
        bq = '{8'hA5, 8'h21, 8'h00};
        vecs[2] = mkVec("overflow", bq, 1'b0, 0, 32'h0, 32'h0, 0, 1'b1, 2'b01);
        bq = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        vecs[3] = mkVec("garbage_zero", bq, 1'b0, 0, 32'h0, 32'h0, 1, 1'b0, 2'b00);

        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset/rx_ready", 64'(bus.rx_ready), 64'd0);
        checkOutput("reset/pgm", 64'(bus.pgm), 64'd0);
        checkOutput("reset/addr", 64'(bus.addr), 64'd0);
        checkOutput("reset/data", 64'(bus.data), 64'd0);
        checkOutput("reset/busy", 64'(busy), 64'd0);
        checkOutput("reset/done", 64'(done), 64'd0);
        checkOutput("reset/error", 64'(error), 64'd0);
        checkOutput("reset/err_code", 64'(err_code), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) applyStimulus(vecs[v]);

        // A byte presented right after a word's last byte must wait out exactly the WRITE cycle
        clearMonitor();
        for (int i = 0; i < 7; i++) sendByte(vecs[0].bytes[i], c);
        sendByte(vecs[0].bytes[7], c);
        checkOutput("stall/cycles", 64'(c), 64'd2);
        checkOutput("stall/writes_so_far", 64'(wr_addr.size()), 64'd1);
        for (int i = 8; i < 12; i++) sendByte(vecs[0].bytes[i], c);
        repeat (3) @(negedge clk);
        checkOutput("stall/writes", 64'(wr_addr.size()), 64'd2);
        checkOutput("stall/done", 64'(done_cnt), 64'd1);
        checkOutput("stall/cycle_rules", 64'(viol), 64'd0);

        // Full-memory frame: 32 words, last one lands at address 31 and addr wraps to 0
        clearMonitor();
        sum = 8'h20;
        sendByte(8'hA5, c);
        sendByte(8'h20, c);
        sendByte(8'h00, c);
        for (int w = 0; w < 32; w++) begin
            sendByte(8'(w), c);
            sendByte(8'h00, c);
            sendByte(8'h00, c);
            sendByte(8'h5A, c);
            sum = sum + 8'(w) + 8'h5A;
        end
        sendByte(sum, c);
        repeat (3) @(negedge clk);
        checkOutput("full/writes", 64'(wr_addr.size()), 64'd32);
        for (int k = 0; k < wr_addr.size() && k < 32; k++) begin
            checkOutput("full/addr", 64'(wr_addr[k]), 64'(k));
            checkOutput("full/data", 64'(wr_data[k]), 64'({8'h5A, 16'h0000, 8'(k)}));
        end
        checkOutput("full/done", 64'(done_cnt), 64'd1);
        checkOutput("full/error", 64'(error), 64'd0);
        checkOutput("full/addr_wrap", 64'(bus.addr), 64'd0);
        checkOutput("full/cycle_rules", 64'(viol), 64'd0);

        // Reset after two data bytes of word 0, then a clean frame
        clearMonitor();
        for (int i = 0; i < 5; i++) sendByte(vecs[0].bytes[i], c);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset/writes", 64'(wr_addr.size()), 64'd0);
        checkOutput("midreset/busy", 64'(busy), 64'd0);
        checkOutput("midreset/addr", 64'(bus.addr), 64'd0);
        checkOutput("midreset/data", 64'(bus.data), 64'd0);
        checkOutput("midreset/rx_ready", 64'(bus.rx_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream boot loader directly upstream of the program memory's write port (pgm/addr/data).
- Receives a framed image over an 8-bit valid/ready stream, typically from the UART receiver.
- Assembles STEP-byte little-endian words and writes them to consecutive word addresses starting at 0.
- Holds the core via busy while loading, and reports completion and any errors.

Parameters:
- INSTR_ADDR_WIDTH, 20, word-address width; must match the program memory.
- STEP, 4, bytes per memory word; must match the program memory.
- MAGIC, 8'hA5, frame start byte.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader can accept a byte.
- pgm  output  1  memory write strobe, one cycle per word.
- addr  output  INSTR_ADDR_WIDTH  word address for the write.
- data  output  STEP*8  word to write.
- busy  output  1  frame in progress; the core is held.
- done  output  1  one-cycle pulse when a frame ends with a good checksum.
- error  output  1  sticky; cleared when the next MAGIC is accepted.
- err_code  output  2  00 none, 01 count overflow, 10 checksum mismatch.

Behaviour:
- Accept rule: a byte is accepted only on a cycle where rx_valid and rx_ready are both 1.
- Frame format: MAGIC, CNT_LO, CNT_HI, then CNT words of STEP bytes each (LSB first), then CHK.
- Checksum rule: CHK = mod-256 sum of CNT_LO, CNT_HI and every data byte. MAGIC is excluded.
- Reset values: rx_ready=0, pgm=0, addr=0, data=0, busy=0, done=0, error=0, err_code=00. FSM goes to IDLE; internal counters and running sum are cleared.
- States:
  - IDLE:
    - rx_ready=1.
    - A non-MAGIC byte is consumed and discarded.
    - MAGIC -> CNT0; clear error/err_code, sum, byte index and addr; set busy=1.
  - CNT0: rx_ready=1; latch CNT_LO, add it to sum -> CNT1.
  - CNT1:
    - rx_ready=1; latch CNT_HI and add it to sum.
    - If the 16-bit count exceeds 2**INSTR_ADDR_WIDTH: error=1, err_code=01, busy=0 -> IDLE.
    - Else if count==0 -> CHK.
    - Else -> DATA.
  - DATA:
    - rx_ready=1.
    - Byte k (0..STEP-1) goes into data[8k+7:8k], and is added to sum.
    - On byte STEP-1 -> WRITE.
  - WRITE:
    - Exactly one cycle; rx_ready=0, pgm=1, addr and data stable.
    - Next cycle: addr+1, words_left-1, byte index 0.
    - If words_left becomes 0 -> CHK, else -> DATA.
  - CHK:
    - rx_ready=1; compare the received byte with sum.
    - Match: done pulses 1 for one cycle.
    - Mismatch: error=1, err_code=10.
    - Either way busy=0 -> IDLE.
- Write timing: pgm asserts the cycle after the last byte of a word is accepted. Maximum throughput is one byte per cycle plus one stall cycle per word.
- pgm is 0 in every state except WRITE.
- No rollback: words already written stay in memory if the checksum fails or overflows.
- Overflow check: count == 2**INSTR_ADDR_WIDTH is legal. The last write goes to the top address and addr then wraps to 0 unused.
- Internal counter widths:
  - Word counter: 17 bits, so INSTR_ADDR_WIDTH up to 16 is fully checked; wider memories accept any 16-bit count.
  - Byte index: $clog2(STEP) bits, minimum 1.
- rx_valid dropping mid-word simply stalls the FSM; no timeout.
- A MAGIC byte value inside DATA/CNT/CHK is treated as data, never as a resync.
- Reset mid-frame: immediate return to reset values. A partially assembled word is discarded and no pgm is issued.
- done and error never assert in the same cycle.

Decomposition:
- Shared package (loader_pkg) holds:
  - FSM state encoding: IDLE, CNT0, CNT1, DATA, WRITE, CHK.
  - MAGIC default.
  - ERR_NONE/ERR_COUNT/ERR_SUM codes.
- One natural sub-module, word_assembler: byte-index counter plus shift-in into the STEP*8 register. It has load/clear controls and a last_byte flag.
- FSM, checksum and address counter stay in program_loader.

Test Plan (INSTR_ADDR_WIDTH=5, STEP=4):
1. Basic load. Stream A5 02 00 13 00 00 00 93 00 10 00 CHK=B8.
   - pgm pulses twice: addr 0 data 32'h00000013, then addr 1 data 32'h00100093.
   - done pulses once; busy falls the same cycle; error=0.
2. Bad checksum. Same frame with CHK=B9.
   - Both writes still occur.
   - error=1, err_code=10, done never asserts.
3. Overflow. Stream A5 21 00.
   - error=1, err_code=01, no pgm, back in IDLE.
   - Count 20 00 (32 words) is accepted; the last write goes to addr 31.
4. Garbage and zero count. Send 00 FF, then A5 00 00 00.
   - Leading bytes are discarded.
   - No pgm; done pulses; a preceding error is cleared at MAGIC.
5. Backpressure and gaps. Random rx_valid gaps during scenario 1.
   - Identical writes.
   - rx_ready=0 exactly on the WRITE cycles; a byte held across WRITE is accepted the next cycle.
6. Reset mid-frame. Assert reset after 2 data bytes of word 0.
   - No pgm; busy=0; addr=0.
   - A following full scenario-1 frame loads correctly.
